// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO.
// Optional abort on flush: define MULDIV_CANCEL_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             is_div;
  logic             q_neg;
  logic             r_neg;

  logic             cancel_act;
  logic             go;
  logic             mv;
  logic             sgn;
  logic             sa;
  logic             sb;
  logic             b_zero;
  logic [WIDTH-1:0] am;
  logic [WIDTH-1:0] bm;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] pfix;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

`ifdef MULDIV_CANCEL_EN
  assign cancel_act = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_act = 1'b0;
`endif

  assign go = start & (state == IDLE) & ~op[2];
  assign mv = start & (state == IDLE) & op[2] & ~op[1];

  assign sgn    = ~op[0];
  assign sa     = sgn & a[WIDTH-1];
  assign sb     = sgn & b[WIDTH-1];
  assign b_zero = (b == '0);
  assign am     = sa ? -a : a;
  assign bm     = sb ? -b : b;

  assign msum  = {1'b0, r} + (q[0] ? {1'b0, d} : '0);
  assign trial = {r, q[WIDTH-1]} - {1'b0, d};

  assign prod = {r, q};
  assign pfix = q_neg ? -prod : prod;
  assign quo  = q_neg ? -q : q;
  assign rem  = r_neg ? -r : r;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = CALC;
      CALC: begin
        if (cancel_act)     state_nxt = IDLE;
        else if (cnt == '0) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      r      <= '0;
      q      <= '0;
      d      <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            is_div <= op[1];
            cnt    <= CNT_TOP;
            r      <= '0;
            if (op[1]) begin
              q     <= am;
              d     <= bm;
              q_neg <= (sa ^ sb) & ~b_zero;
              r_neg <= sa;
            end else begin
              q     <= bm;
              d     <= am;
              q_neg <= sa ^ sb;
              r_neg <= 1'b0;
            end
          end else if (mv) begin
            if (op[0]) lo <= a;
            else       hi <= a;
          end
        end
        CALC: begin
          if (!cancel_act) begin
            cnt <= cnt - 1'b1;
            // restoring divide keeps the remainder only when the trial is non-negative
            if (is_div) begin
              if (!trial[WIDTH]) begin
                r <= trial[WIDTH-1:0];
                q <= {q[WIDTH-2:0], 1'b1};
              end else begin
                r <= {r[WIDTH-2:0], q[WIDTH-1]};
                q <= {q[WIDTH-2:0], 1'b0};
              end
            end else begin
              r <= msum[WIDTH:1];
              q <= {msum[0], q[WIDTH-1:1]};
            end
          end
        end
        FIX: begin
          if (!cancel_act) begin
            done <= 1'b1;
            if (is_div) begin
              lo <= quo;
              hi <= rem;
            end else begin
              {hi, lo} <= pfix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32).
// Follows MULDIV_CANCEL_EN for the flush scenario.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;
  int          n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done hi=%h lo=%h", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_hi"}, hi, e.hi);
        chk({e.nm, "_lo"}, lo, e.lo);
      end
    end
  end

  task automatic issue(logic [2:0] o, logic [31:0] x,
                       logic [31:0] y, logic [31:0] eh,
                       logic [31:0] el, string nm);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.hi  = eh;
    e.lo  = el;
    e.nm  = nm;
    sb.push_back(e);
    cur_hi = eh;
    cur_lo = el;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    bit got;
    cnt = 0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy === 1'b1) cnt++;
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout act=0 exp=1");
    end
  endtask

  task automatic move(logic [2:0] o, logic [31:0] x);
    start = 1'b1;
    op    = o;
    a     = x;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    cancel   = 1'b0;
    op       = 3'd0;
    a        = '0;
    b        = '0;
    cur_hi   = '0;
    cur_lo   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(3'd0, 32'hFFFFFFFD, 32'd5,
          32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg");
    wait_done(n);
    chk("busy_len", n, 32'd33);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, "multu_max");
    wait_done(n);
    issue(3'd0, 32'd7, 32'd6, 32'h0, 32'd42, "b2b_mult");
    wait_done(n);
    chk("b2b_busy_len", n, 32'd33);

    issue(3'd0, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h0, "mult_minmin");
    wait_done(n);
    issue(3'd2, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    wait_done(n);
    issue(3'd2, 32'd7, 32'hFFFFFFFE,
          32'h1, 32'hFFFFFFFD, "div_negb");
    wait_done(n);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF,
          32'h0, 32'h80000000, "div_ovf");
    wait_done(n);
    issue(3'd2, 32'hFFFFFF9C, 32'h0,
          32'hFFFFFF9C, 32'hFFFFFFFF, "div_zero");
    wait_done(n);
    issue(3'd3, 32'h1234, 32'h0,
          32'h1234, 32'hFFFFFFFF, "divu_zero");
    wait_done(n);
    chk("dz_busy_len", n, 32'd33);

    @(negedge clk);
    move(3'd4, 32'hA5A5A5A5);
    cur_hi = 32'hA5A5A5A5;
    chk("mthi_hi", hi, cur_hi);
    chk("mthi_lo", lo, cur_lo);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_done", {31'b0, done}, 32'd0);
    move(3'd5, 32'h0BADF00D);
    cur_lo = 32'h0BADF00D;
    chk("mtlo_lo", lo, cur_lo);
    chk("mtlo_hi", hi, cur_hi);

    move(3'd6, 32'h1);
    chk("nop_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("nop_hi", hi, cur_hi);
    chk("nop_lo", lo, cur_lo);

    issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_ign");
    repeat (3) @(negedge clk);
    start = 1'b1;
    op    = 3'd1;
    a     = 32'd5;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (40) @(negedge clk);
    chk("ign_busy", {31'b0, busy}, 32'd0);
    chk("ign_lo", lo, 32'd14);

    begin
      logic [31:0] ph;
      logic [31:0] pl;
      ph = cur_hi;
      pl = cur_lo;
      issue(3'd0, 32'd3, 32'd4, 32'd0, 32'd12, "mult_cxl");
      repeat (4) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
`ifdef MULDIV_CANCEL_EN
      void'(sb.pop_back());
      cur_hi = ph;
      cur_lo = pl;
      chk("cxl_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      chk("cxl_hi", hi, ph);
      chk("cxl_lo", lo, pl);
`else
      chk("cxl_busy", {31'b0, busy}, 32'd1);
      wait_done(n);
      @(negedge clk);
      chk("cxl_hi", hi, 32'd0);
      chk("cxl_lo", lo, 32'd12);
`endif
    end

    @(negedge clk);
    issue(3'd2, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, "div_rst");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_lo", lo, 32'h0);

    issue(3'd1, 32'd7, 32'd6, 32'h0, 32'd42, "multu_after");
    wait_done(n);
    repeat (3) @(negedge clk);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover act=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
